// File: rtl/mux2_pkg.sv
// Shared constants and types for the wide 2:1 datapath selector.
`timescale 1ns/1ps
package mux2_pkg;

   localparam int MUX2_DEF_WIDTH = 64;

   typedef logic [MUX2_DEF_WIDTH-1:0] mux2_word_t;

endpackage

// File: rtl/mux2_bit.sv
// Single-bit 2:1 cell. A ternary keeps standard mux pessimism: an X select
// still yields i0 when both operands agree.
`timescale 1ns/1ps
module mux2_bit (
   output logic out,
   input  logic i0,
   input  logic i1,
   input  logic sel
);

   assign out = sel ? i1 : i0;

endmodule

// File: rtl/mux2_wide_reg.sv
// WIDTH-bit 2:1 selector with combinational and registered outputs.
// Define MUX2_PARITY_EN to add a registered even-parity output par_q.
`timescale 1ns/1ps
module mux2_wide_reg
   import mux2_pkg::*;
#(
   parameter int WIDTH = MUX2_DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i0,
   input  logic [WIDTH-1:0] i1,
   input  logic             sel,
   input  logic             en,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] out_q
`ifdef MUX2_PARITY_EN
   ,
   output logic             par_q
`endif
);

   // One cell per bit keeps the select-to-output path a single cell deep.
   for (genvar k = 0; k < WIDTH; k++) begin : eachMux
      mux2_bit u_bit (
         .out (out[k]),
         .i0  (i0[k]),
         .i1  (i1[k]),
         .sel (sel)
      );
   end

   logic [WIDTH-1:0] out_d;
   assign out_d = out;

`ifdef MUX2_PARITY_EN
   logic par_d;
   assign par_d = ^out_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q <= '0;
         par_q <= 1'b0;
      end else if (en) begin
         out_q <= out_d;
         par_q <= par_d;
      end
   end
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q <= '0;
      end else if (en) begin
         out_q <= out_d;
      end
   end
`endif

endmodule

// File: tb/tb_mux2_wide_reg.sv
// Directed self-checking bench for mux2_wide_reg (parity checks under MUX2_PARITY_EN).
`timescale 1ns/1ps
module tb_mux2_wide_reg;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] i0, i1;
   logic        sel, en;
   logic [63:0] out, out_q;
`ifdef MUX2_PARITY_EN
   logic        par_q;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mux2_wide_reg #(.WIDTH(64)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .i0    (i0),
      .i1    (i1),
      .sel   (sel),
      .en    (en),
      .out   (out),
      .out_q (out_q)
`ifdef MUX2_PARITY_EN
      ,
      .par_q (par_q)
`endif
   );

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b1; sel = 1'b1;
      i0 = 64'h0123_4567_89AB_CDEF; i1 = 64'hFEDC_BA98_7654_3210;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (out_q !== 64'h0) begin errors++; $display("FAIL reset_out_q got=%h exp=%h", out_q, 64'h0); end
      checks++;
      if (out !== 64'hFEDC_BA98_7654_3210) begin errors++; $display("FAIL reset_out_comb got=%h exp=%h", out, 64'hFEDC_BA98_7654_3210); end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (out_q !== 64'hFEDC_BA98_7654_3210) begin errors++; $display("FAIL first_capture got=%h exp=%h", out_q, 64'hFEDC_BA98_7654_3210); end
   endtask

   task automatic test_mux_sel();
      @(negedge clk);
      en = 1'b0; sel = 1'b0; i0 = 64'd4; i1 = 64'd64;
      #0.2;
      checks++;
      if (out !== 64'd4) begin errors++; $display("FAIL mux_sel0 got=%h exp=%h", out, 64'd4); end
      sel = 1'b1;
      #0.15;
      checks++;
      if (out !== 64'd64) begin errors++; $display("FAIL mux_sel1 got=%h exp=%h", out, 64'd64); end
   endtask

   task automatic test_per_bit();
      i0 = 64'hAAAA_AAAA_AAAA_AAAA; i1 = 64'h5555_5555_5555_5555;
      for (int n = 0; n < 4; n++) begin
         sel = n[0];
         #0.2;
         checks++;
         if (out !== (n[0] ? 64'h5555_5555_5555_5555 : 64'hAAAA_AAAA_AAAA_AAAA)) begin
            errors++; $display("FAIL per_bit step=%0d got=%h", n, out);
         end
      end
   endtask

   task automatic test_register_load();
      @(negedge clk);
      en = 1'b1; sel = 1'b1; i0 = 64'd4; i1 = 64'd64;
      @(posedge clk); #1;
      checks++;
      if (out_q !== 64'd64) begin errors++; $display("FAIL reg_load got=%h exp=%h", out_q, 64'd64); end
      @(negedge clk);
      en = 1'b0; sel = 1'b0; i0 = 64'd7; i1 = 64'd99;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (out_q !== 64'd64) begin errors++; $display("FAIL reg_hold got=%h exp=%h", out_q, 64'd64); end
      checks++;
      if (out !== 64'd7) begin errors++; $display("FAIL hold_out_comb got=%h exp=%h", out, 64'd7); end
   endtask

   task automatic test_async_reset();
      // out_q=64 here, one ns past a rising edge
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_q !== 64'h0) begin errors++; $display("FAIL async_clear got=%h exp=%h", out_q, 64'h0); end
      sel = 1'b1;
      #1;
      checks++;
      if (out !== 64'd99) begin errors++; $display("FAIL reset_tracks got=%h exp=%h", out, 64'd99); end
      en = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_q !== 64'h0) begin errors++; $display("FAIL reset_overrides_en got=%h exp=%h", out_q, 64'h0); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_back_to_back();
      logic        t_sel [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic [63:0] t_i0  [4] = '{64'h1111, 64'hFFFF_0000_FFFF_0000, 64'h8000_0000_0000_0001, 64'h0};
      logic [63:0] t_i1  [4] = '{64'h2222, 64'h0000_FFFF_0000_FFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
      logic [63:0] t_exp [4] = '{64'h1111, 64'h0000_FFFF_0000_FFFF, 64'h8000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF};
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         en = 1'b1; sel = t_sel[n]; i0 = t_i0[n]; i1 = t_i1[n];
         @(posedge clk); #1;
         checks++;
         if (out_q !== t_exp[n]) begin errors++; $display("FAIL b2b step=%0d got=%h exp=%h", n, out_q, t_exp[n]); end
      end
      @(negedge clk);
      en = 1'b0;
   endtask

`ifdef MUX2_PARITY_EN
   task automatic test_parity();
      @(negedge clk);
      en = 1'b1; sel = 1'b0; i0 = 64'h7;
      @(posedge clk); #1;
      checks++;
      if (par_q !== 1'b1) begin errors++; $display("FAIL parity_7 got=%b exp=1", par_q); end
      @(negedge clk);
      i0 = 64'h3;
      @(posedge clk); #1;
      checks++;
      if (par_q !== 1'b0) begin errors++; $display("FAIL parity_3 got=%b exp=0", par_q); end
      @(negedge clk);
      i0 = 64'h1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (par_q !== 1'b0) begin errors++; $display("FAIL parity_reset got=%b exp=0", par_q); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask
`endif

   initial begin
      test_reset();
      test_mux_sel();
      test_per_bit();
      test_register_load();
      test_async_reset();
      test_back_to_back();
`ifdef MUX2_PARITY_EN
      test_parity();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
